// File: rtl/pl_pkg.sv
// Shared definitions for the memory/writeback stage.
//   - Bit positions inside the EX pipeline register (ex_reg, [0:6] ordering).
//   - Bit positions inside the branch-condition vector (ex_br_conds, [0:4]).
//   - Bit positions inside the architectural flag register (flags, [0:3]).
//   - Data-memory interface FSM state encoding.
package pl_pkg;

  localparam int EX_REG_STORE      = 0;
  localparam int EX_REG_WR_EN      = 1;
  localparam int EX_REG_SAVE_COUT  = 2;
  localparam int EX_REG_INVALIDATE = 3;
  localparam int EX_REG_LOAD       = 4;
  localparam int EX_REG_INV_FETCH  = 5;
  localparam int EX_REG_INV_DECODE = 6;

  localparam int BR_GT       = 0;
  localparam int BR_LT       = 1;
  localparam int BR_EQ       = 2;
  localparam int BR_CARRY    = 3;
  localparam int BR_CMP_TRUE = 4;

  localparam int FLAG_GT    = 0;
  localparam int FLAG_LT    = 1;
  localparam int FLAG_EQ    = 2;
  localparam int FLAG_CARRY = 3;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } dmem_state_t;

endpackage

// File: rtl/pl_dmem_if.sv
// Data-memory request engine for the memory/writeback stage.
// Accepts one store or load in IDLE, raises a registered request and holds
// it stable until the memory acknowledges, stalling upstream meanwhile.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   store_vld/load_vld  qualified memory instruction presented in IDLE
//   st_data, wr_addr, rd_addr, dest_addr   EX-stage operands
//   idle              FSM is in IDLE (EX inputs are being consumed)
//   dmem_req/we/addr/wdata, dmem_ack       memory handshake
//   stall             hold EX and earlier stages
//   ld_done           load acknowledged this cycle (dmem_rdata valid)
//   ld_dest           register destination captured with the load
module pl_dmem_if
  import pl_pkg::*;
#(
  parameter int DW       = 8,
  parameter int ADDR_WID = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                store_vld,
  input  logic                load_vld,
  input  logic [DW-1:0]       st_data,
  input  logic [ADDR_WID-1:0] wr_addr,
  input  logic [ADDR_WID-1:0] rd_addr,
  input  logic [2:0]          dest_addr,
  output logic                idle,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_WID-1:0] dmem_addr,
  output logic [DW-1:0]       dmem_wdata,
  input  logic                dmem_ack,
  output logic                stall,
  output logic                ld_done,
  output logic [2:0]          ld_dest
);

  dmem_state_t state;

  // Capture stage: request registers load from EX in IDLE, release on ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      ld_dest    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Store wins when both store and load bits are set.
          if (store_vld) begin
            dmem_req   <= 1'b1;
            dmem_we    <= 1'b1;
            dmem_addr  <= wr_addr;
            dmem_wdata <= st_data;
            state      <= MEM_WAIT;
          end else if (load_vld) begin
            dmem_req  <= 1'b1;
            dmem_we   <= 1'b0;
            dmem_addr <= rd_addr;
            ld_dest   <= dest_addr;
            state     <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

  // Stall releases combinationally in the ack cycle so upstream can advance
  // on the same edge that retires the request.
  assign idle    = (state == IDLE);
  assign stall   = (state == MEM_WAIT) && !dmem_ack;
  assign ld_done = (state == MEM_WAIT) && dmem_ack && !dmem_we;

endmodule

// File: rtl/pl_mem_wb.sv
// Memory/writeback pipeline stage.
// Consumes the EX pipeline register, drives data-memory requests through
// pl_dmem_if, writes the register file and maintains the gt/lt/eq/carry
// flag register used by jumps.
// Ports:
//   clk, reset                   clock (rising edge), async active-low reset
//   ex_reg[0:6]                  {store, reg_wr_en, save_cout, invalidate_ex,
//                                 load, inv_fetch, inv_decode}
//   ex_result, ex_dest_addr, ex_wr_addr, ex_rd_addr, ex_br_conds[0:4]
//   dmem_req/we/addr/wdata/rdata/ack  data-memory handshake
//   stall                        hold EX and earlier stages
//   rf_wr_en/addr/data           register-file write port
//   flags[0:3]                   {gt, lt, eq, carry}
//   fwd_valid/addr/data          forwarding tap
// Configuration macro: PL_MEMWB_FWD_EN enables the forwarding tap; when it is
// undefined the fwd_* ports are tied to zero.
module pl_mem_wb
  import pl_pkg::*;
#(
  parameter int NUM_DOMAINS = 1,
  parameter int ADDR_WID    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [0:6]                  ex_reg,
  input  logic [NUM_DOMAINS*8-1:0]    ex_result,
  input  logic [2:0]                  ex_dest_addr,
  input  logic [ADDR_WID-1:0]         ex_wr_addr,
  input  logic [ADDR_WID-1:0]         ex_rd_addr,
  input  logic [0:4]                  ex_br_conds,
  output logic                        dmem_req,
  output logic                        dmem_we,
  output logic [ADDR_WID-1:0]         dmem_addr,
  output logic [NUM_DOMAINS*8-1:0]    dmem_wdata,
  input  logic [NUM_DOMAINS*8-1:0]    dmem_rdata,
  input  logic                        dmem_ack,
  output logic                        stall,
  output logic                        rf_wr_en,
  output logic [2:0]                  rf_wr_addr,
  output logic [NUM_DOMAINS*8-1:0]    rf_wr_data,
  output logic [0:3]                  flags,
  output logic                        fwd_valid,
  output logic [2:0]                  fwd_addr,
  output logic [NUM_DOMAINS*8-1:0]    fwd_data
);

  localparam int DW = NUM_DOMAINS * 8;

  logic       idle;
  logic       valid;
  logic       store_vld;
  logic       load_vld;
  logic       alu_wr;
  logic       ld_done;
  logic [2:0] ld_dest;
  logic       unused_ex_bits;

  // Fetch/decode invalidation bits are consumed by earlier stages.
  assign unused_ex_bits = ^ex_reg[EX_REG_INV_FETCH:EX_REG_INV_DECODE];

  // EX inputs only count while the memory engine is idle.
  assign valid     = idle && !ex_reg[EX_REG_INVALIDATE];
  assign store_vld = valid && ex_reg[EX_REG_STORE];
  assign load_vld  = valid && ex_reg[EX_REG_LOAD];
  assign alu_wr    = valid && ex_reg[EX_REG_WR_EN]
                     && !ex_reg[EX_REG_STORE] && !ex_reg[EX_REG_LOAD];

  pl_dmem_if #(
    .DW       (DW),
    .ADDR_WID (ADDR_WID)
  ) u_dmem_if (
    .clk        (clk),
    .reset      (reset),
    .store_vld  (store_vld),
    .load_vld   (load_vld),
    .st_data    (ex_result),
    .wr_addr    (ex_wr_addr),
    .rd_addr    (ex_rd_addr),
    .dest_addr  (ex_dest_addr),
    .idle       (idle),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .stall      (stall),
    .ld_done    (ld_done),
    .ld_dest    (ld_dest)
  );

  // Writeback stage: regfile write port and flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      flags      <= '0;
    end else begin
      rf_wr_en <= 1'b0;
      // A load ack and an ALU write never coincide: ALU writes need IDLE.
      if (ld_done) begin
        rf_wr_en   <= 1'b1;
        rf_wr_addr <= ld_dest;
        rf_wr_data <= dmem_rdata;
      end else if (alu_wr) begin
        rf_wr_en   <= 1'b1;
        rf_wr_addr <= ex_dest_addr;
        rf_wr_data <= ex_result;
      end
      if (valid && ex_br_conds[BR_CMP_TRUE]) begin
        flags[FLAG_GT] <= ex_br_conds[BR_GT];
        flags[FLAG_LT] <= ex_br_conds[BR_LT];
        flags[FLAG_EQ] <= ex_br_conds[BR_EQ];
      end
      if (valid && ex_reg[EX_REG_SAVE_COUT]) begin
        flags[FLAG_CARRY] <= ex_br_conds[BR_CARRY];
      end
    end
  end

`ifdef PL_MEMWB_FWD_EN
  // Gated by idle so nothing is forwarded while a load is outstanding.
  assign fwd_valid = rf_wr_en && idle;
  assign fwd_addr  = rf_wr_addr;
  assign fwd_data  = rf_wr_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_pl_mem_wb.sv
module tb_pl_mem_wb;

  logic       clk;
  logic       reset;
  logic [0:6] ex_reg;
  logic [7:0] ex_result;
  logic [2:0] ex_dest_addr;
  logic [7:0] ex_wr_addr;
  logic [7:0] ex_rd_addr;
  logic [0:4] ex_br_conds;
  logic       dmem_req;
  logic       dmem_we;
  logic [7:0] dmem_addr;
  logic [7:0] dmem_wdata;
  logic [7:0] dmem_rdata;
  logic       dmem_ack;
  logic       stall;
  logic       rf_wr_en;
  logic [2:0] rf_wr_addr;
  logic [7:0] rf_wr_data;
  logic [0:3] flags;
  logic       fwd_valid;
  logic [2:0] fwd_addr;
  logic [7:0] fwd_data;

  int n_tests = 0;
  int n_fail  = 0;

  pl_mem_wb #(
    .NUM_DOMAINS (1),
    .ADDR_WID    (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_reg       (ex_reg),
    .ex_result    (ex_result),
    .ex_dest_addr (ex_dest_addr),
    .ex_wr_addr   (ex_wr_addr),
    .ex_rd_addr   (ex_rd_addr),
    .ex_br_conds  (ex_br_conds),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack),
    .stall        (stall),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .flags        (flags),
    .fwd_valid    (fwd_valid),
    .fwd_addr     (fwd_addr),
    .fwd_data     (fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_ex(input logic [6:0] r, input logic [7:0] res, input logic [2:0] dest,
                          input logic [7:0] wa, input logic [7:0] ra, input logic [4:0] conds);
    ex_reg       = r;
    ex_result    = res;
    ex_dest_addr = dest;
    ex_wr_addr   = wa;
    ex_rd_addr   = ra;
    ex_br_conds  = conds;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample point half a cycle away from the active edge.
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic check_fwd(input string tag, input logic v, input logic [2:0] a, input logic [7:0] d);
`ifdef PL_MEMWB_FWD_EN
    check_eq({tag, "_fwd_valid"}, {31'd0, fwd_valid}, {31'd0, v});
    check_eq({tag, "_fwd_addr"},  {29'd0, fwd_addr},  {29'd0, a});
    check_eq({tag, "_fwd_data"},  {24'd0, fwd_data},  {24'd0, d});
`else
    check_eq({tag, "_fwd_valid"}, {31'd0, fwd_valid}, 32'd0);
    check_eq({tag, "_fwd_data"},  {24'd0, fwd_data},  32'd0);
    if (v === 1'bx) check_eq({tag, "_fwd_addr"}, {29'd0, fwd_addr}, {29'd0, a});
`endif
  endtask

  initial begin
    reset      = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 8'h00;
    drive_ex(7'b0000000, 8'h00, 3'd0, 8'h00, 8'h00, 5'b00000);
    #1 reset = 1'b0;
    #1;
    check_eq("rst_req",   {31'd0, dmem_req}, 32'd0);
    check_eq("rst_rfwr",  {31'd0, rf_wr_en}, 32'd0);
    check_eq("rst_stall", {31'd0, stall},    32'd0);
    check_eq("rst_flags", {28'd0, flags},    32'd0);
    tick();
    tick();
    reset = 1'b1;

    // ---------------- store, ack on the third request cycle
    tick();
    drive_ex(7'b1000000, 8'hA5, 3'd0, 8'h10, 8'h00, 5'b00000);
    mid();
    check_eq("st_pre_req", {31'd0, dmem_req}, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) dmem_ack = 1'b1;
      mid();
      check_eq($sformatf("st_req_c%0d", c),   {31'd0, dmem_req},   32'd1);
      check_eq($sformatf("st_we_c%0d", c),    {31'd0, dmem_we},    32'd1);
      check_eq($sformatf("st_addr_c%0d", c),  {24'd0, dmem_addr},  32'h10);
      check_eq($sformatf("st_wdata_c%0d", c), {24'd0, dmem_wdata}, 32'hA5);
      check_eq($sformatf("st_stall_c%0d", c), {31'd0, stall},      (c < 3) ? 32'd1 : 32'd0);
      check_eq($sformatf("st_rfwr_c%0d", c),  {31'd0, rf_wr_en},   32'd0);
    end
    tick();
    dmem_ack = 1'b0;
    drive_ex(7'b0000000, 8'h00, 3'd0, 8'h00, 8'h00, 5'b00000);
    mid();
    check_eq("st_post_req",  {31'd0, dmem_req}, 32'd0);
    check_eq("st_post_rfwr", {31'd0, rf_wr_en}, 32'd0);
    check_eq("st_post_stall",{31'd0, stall},    32'd0);

    // ---------------- load, ack in the first request cycle
    tick();
    drive_ex(7'b0100100, 8'h00, 3'd3, 8'h00, 8'h22, 5'b00000);
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 8'h5C;
    mid();
    check_eq("ld_req",   {31'd0, dmem_req},  32'd1);
    check_eq("ld_we",    {31'd0, dmem_we},   32'd0);
    check_eq("ld_addr",  {24'd0, dmem_addr}, 32'h22);
    check_eq("ld_stall", {31'd0, stall},     32'd0);
    check_eq("ld_rfwr0", {31'd0, rf_wr_en},  32'd0);
    check_fwd("ld_wait", 1'b0, 3'd0, 8'h00);
    tick();
    dmem_ack   = 1'b0;
    dmem_rdata = 8'h00;
    drive_ex(7'b0000000, 8'h00, 3'd0, 8'h00, 8'h00, 5'b00000);
    mid();
    check_eq("ld_rfwr1",  {31'd0, rf_wr_en},   32'd1);
    check_eq("ld_rfaddr", {29'd0, rf_wr_addr}, 32'd3);
    check_eq("ld_rfdata", {24'd0, rf_wr_data}, 32'h5C);
    check_eq("ld_req_off",{31'd0, dmem_req},   32'd0);
    check_eq("ld_stall1", {31'd0, stall},      32'd0);
    check_fwd("ld_wb", 1'b1, 3'd3, 8'h5C);
    tick();
    mid();
    check_eq("ld_rfwr2", {31'd0, rf_wr_en}, 32'd0);

    // ---------------- flags: compare then save_cout
    drive_ex(7'b0000000, 8'h00, 3'd0, 8'h00, 8'h00, 5'b00101);
    tick();
    drive_ex(7'b0110000, 8'h3C, 3'd5, 8'h00, 8'h00, 5'b00010);
    mid();
    check_eq("cmp_flags", {28'd0, flags}, 32'b0010);
    tick();
    drive_ex(7'b0000000, 8'h00, 3'd0, 8'h00, 8'h00, 5'b10001);
    mid();
    check_eq("cout_flags", {28'd0, flags},      32'b0011);
    check_eq("alu_rfwr",   {31'd0, rf_wr_en},   32'd1);
    check_eq("alu_rfaddr", {29'd0, rf_wr_addr}, 32'd5);
    check_eq("alu_rfdata", {24'd0, rf_wr_data}, 32'h3C);
    check_fwd("alu", 1'b1, 3'd5, 8'h3C);
    tick();
    drive_ex(7'b1101000, 8'h99, 3'd7, 8'h44, 8'h00, 5'b01001);
    mid();
    check_eq("gt_flags", {28'd0, flags}, 32'b1001);
    check_eq("gt_rfwr",  {31'd0, rf_wr_en}, 32'd0);

    // ---------------- invalidated store+wr_en+compare
    tick();
    drive_ex(7'b0000000, 8'h00, 3'd0, 8'h00, 8'h00, 5'b00000);
    mid();
    check_eq("inv_req",   {31'd0, dmem_req}, 32'd0);
    check_eq("inv_rfwr",  {31'd0, rf_wr_en}, 32'd0);
    check_eq("inv_flags", {28'd0, flags},    32'b1001);
    check_eq("inv_stall", {31'd0, stall},    32'd0);

    // ---------------- back-to-back store then load
    tick();
    drive_ex(7'b1000000, 8'h11, 3'd0, 8'h30, 8'h00, 5'b00000);
    tick();
    dmem_ack = 1'b1;
    mid();
    check_eq("b2b_st_addr",  {24'd0, dmem_addr}, 32'h30);
    check_eq("b2b_st_stall", {31'd0, stall},     32'd0);
    tick();
    dmem_ack = 1'b0;
    drive_ex(7'b0000100, 8'h00, 3'd6, 8'h00, 8'h40, 5'b00000);
    mid();
    check_eq("b2b_idle_req", {31'd0, dmem_req}, 32'd0);
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 8'h77;
    mid();
    check_eq("b2b_ld_req",  {31'd0, dmem_req},  32'd1);
    check_eq("b2b_ld_we",   {31'd0, dmem_we},   32'd0);
    check_eq("b2b_ld_addr", {24'd0, dmem_addr}, 32'h40);
    tick();
    dmem_ack = 1'b0;
    drive_ex(7'b0000000, 8'h00, 3'd0, 8'h00, 8'h00, 5'b00000);
    mid();
    check_eq("b2b_rfwr",   {31'd0, rf_wr_en},   32'd1);
    check_eq("b2b_rfaddr", {29'd0, rf_wr_addr}, 32'd6);
    check_eq("b2b_rfdata", {24'd0, rf_wr_data}, 32'h77);

    // ---------------- reset asserted during a pending load
    tick();
    drive_ex(7'b0000100, 8'h00, 3'd2, 8'h00, 8'h50, 5'b00000);
    tick();
    mid();
    check_eq("mr_pre_stall", {31'd0, stall},    32'd1);
    check_eq("mr_pre_req",   {31'd0, dmem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("mr_req",   {31'd0, dmem_req}, 32'd0);
    check_eq("mr_stall", {31'd0, stall},    32'd0);
    check_eq("mr_rfwr",  {31'd0, rf_wr_en}, 32'd0);
    check_eq("mr_flags", {28'd0, flags},    32'd0);
    dmem_ack   = 1'b1;
    dmem_rdata = 8'hEE;
    tick();
    reset    = 1'b1;
    dmem_ack = 1'b0;
    drive_ex(7'b0000000, 8'h00, 3'd0, 8'h00, 8'h00, 5'b00000);
    mid();
    check_eq("mr_post_rfwr",  {31'd0, rf_wr_en}, 32'd0);
    check_eq("mr_post_req",   {31'd0, dmem_req}, 32'd0);
    check_eq("mr_post_stall", {31'd0, stall},    32'd0);
    tick();
    mid();
    check_eq("mr_nowrite", {31'd0, rf_wr_en}, 32'd0);
    drive_ex(7'b1000000, 8'h66, 3'd0, 8'h77, 8'h00, 5'b00000);
    tick();
    mid();
    check_eq("mr_idle_req",  {31'd0, dmem_req},   32'd1);
    check_eq("mr_idle_data", {24'd0, dmem_wdata}, 32'h66);
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    drive_ex(7'b0000000, 8'h00, 3'd0, 8'h00, 8'h00, 5'b00000);
    mid();
    check_eq("mr_done_req", {31'd0, dmem_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
